// File: rtl/seq_detector_param.sv
// ============================================================================
// seq_detector_param : runtime-loadable serial pattern detector with valid
// qualification, selectable overlap and a saturating match counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_detector_param #(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             data,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             detected,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q,  det_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [PAT_W-1:0]  w_window;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_accept;
  logic              w_match;

  assign w_window   = {hist_q, data};
  assign w_fill_inc = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
  assign w_accept   = data_valid && !pat_load;
  // The window only counts once PAT_W-1 earlier bits have been accepted.
  assign w_match    = w_accept && (fill_q >= FILL_MAX - 1'b1) && (w_window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    cnt_d  = cnt_q;

    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (data_valid) begin
      hist_d = w_window[PAT_W-2:0];
      if (w_match) begin
        det_d  = 1'b1;
        fill_d = overlap_en ? w_fill_inc : '0;
      end else begin
        fill_d = w_fill_inc;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (w_match && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// tb_seq_detector_param : bench for seq_detector_param (CNT_W=8 and CNT_W=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

  localparam int         PAT_W = 4;
  localparam logic [3:0] DEF   = 4'b1010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic       data = 1'b0;
  logic       overlap_en = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;
  logic       det_a, det_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  seq_detector_param #(.PAT_W(PAT_W), .DEFAULT_PAT(DEF), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .detected(det_a), .match_count(cnt_a)
  );

  seq_detector_param #(.PAT_W(PAT_W), .DEFAULT_PAT(DEF), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .detected(det_b), .match_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit det;
    int c8;
    int c2;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the list of bits accepted since the last clear.
  logic [3:0] m_pat = DEF;
  bit         m_bits[$];
  int         m_c8 = 0;
  int         m_c2 = 0;
  int         step_idx = 0;
  bit         g_ov = 1'b0;

  task automatic chk(input string name, input int idx, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, req);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit d, input bit ov,
                       input bit ld, input logic [3:0] pin, input bit clr);
    exp_t e;
    bit   match;
    int   val;
    @(negedge clk);
    rst = r; data_valid = v; data = d; overlap_en = ov;
    pat_load = ld; pat_in = pin; cnt_clr = clr;
    match = 1'b0;
    if (r) begin
      m_pat = DEF;
      m_bits.delete();
      m_c8 = 0;
      m_c2 = 0;
    end else begin
      if (ld) begin
        m_pat = pin;
        m_bits.delete();
      end else if (v) begin
        m_bits.push_back(d);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (m_bits.size() == PAT_W) begin
          val = 0;
          for (int i = 0; i < PAT_W; i++) val = val * 2 + int'(m_bits[i]);
          match = (val == int'(m_pat));
        end
        if (match && !ov) m_bits.delete();
      end
      if (clr) begin
        m_c8 = 0;
        m_c2 = 0;
      end else if (match) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    e.det = match; e.c8 = m_c8; e.c2 = m_c2; e.idx = step_idx;
    sb.push_back(e);
    step_idx++;
  endtask

  task automatic bitv(input bit d);
    drive(1'b0, 1'b1, d, g_ov, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic idle(input bit d);
    drive(1'b0, 1'b0, d, g_ov, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, g_ov, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic load(input logic [3:0] p);
    drive(1'b0, 1'b0, 1'b0, g_ov, 1'b1, p, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("detected_a", e.idx, int'(det_a), int'(e.det));
        chk("detected_b", e.idx, int'(det_b), int'(e.det));
        chk("count8", e.idx, int'(cnt_a), e.c8);
        chk("count2", e.idx, int'(cnt_b), e.c2);
      end
    end
  end

  initial begin : stimulus
    do_reset();
    do_reset();

    g_ov = 1'b0;
    for (int i = 0; i < 8; i++) bitv(i % 2 == 0);
    do_reset();
    g_ov = 1'b1;
    for (int i = 0; i < 8; i++) bitv(i % 2 == 0);

    load(4'b1111);
    for (int i = 0; i < 6; i++) bitv(1'b1);
    g_ov = 1'b0;
    load(4'b1111);
    for (int i = 0; i < 6; i++) bitv(1'b1);

    do_reset();
    bitv(1'b1); bitv(1'b0);
    idle(1'b1); idle(1'b0); idle(1'b1);
    bitv(1'b1); bitv(1'b0);
    idle(1'b0);

    do_reset();
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    load(4'b0110);
    bitv(1'b0);
    bitv(1'b0); bitv(1'b1); bitv(1'b1); bitv(1'b0);
    idle(1'b0);

    do_reset();
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    do_reset();
    bitv(1'b0);
    idle(1'b0);

    // Five overlapping matches saturate the 2-bit counter; then clear on a match.
    do_reset();
    g_ov = 1'b1;
    for (int i = 0; i < 12; i++) bitv(i % 2 == 0);
    bitv(1'b1);
    drive(1'b0, 1'b1, 1'b0, g_ov, 1'b0, 4'b0000, 1'b1);
    idle(1'b0);

    for (int i = 0; i < 800; i++) begin
      bit r, v, d, ld, clr;
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) g_ov = ~g_ov;
      drive(r, v, d, g_ov, ld, 4'($urandom), clr);
    end

    idle(1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
